instr_exec_unit: RTL and testbench

Sequential execution stage that sits directly downstream of the instruction register. It walks a range of register addresses through `read_pointer`, fetches each `instruction_t`, computes the 64-bit signed `result` for its opcode, and presents each result with a valid/ready handshake to the writeback/scoreboard consumer. MULT is single-cycle; DIV, MOD and POW are iterative with fixed latency.

---
 rtl/instr_exec_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_instr_exec_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_exec_unit.sv
// instr_exec_unit
// ---------------------------------------------------------------------------
// Sequential execution stage placed after the instruction register. It walks
// a range of register addresses, fetches each instruction, computes a 64-bit
// signed result and hands it to the consumer over a valid/ready handshake.
// MULT and the simple ops finish in one EXEC cycle; DIV, MOD and POW iterate
// for exactly 32 EXEC cycles.
//
// Ports:
//   clk              - single clock, rising edge
//   reset_n          - asynchronous active-low reset
//   start            - run request, sampled only while idle
//   start_addr       - first register address of the run
//   count            - number of instructions to execute (0..63)
//   read_pointer     - combinational read address into the instruction register
//   instruction_word - instruction at read_pointer (.result field ignored)
//   result           - computed 64-bit signed result
//   result_opc       - opcode that produced result
//   result_addr      - source address of result
//   result_err       - divide/modulo by zero or illegal opcode
//   result_valid     - result is presented
//   result_ready     - consumer accepts the presented result
//   busy             - unit is not idle
//   done             - one-cycle pulse when a run completes
// ---------------------------------------------------------------------------

package instr_register_pkg;
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7,
        POW   = 4'd8
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] operand_result;
    typedef logic [4:0]         address_t;

    typedef struct packed {
        opcode_t       opc;
        operand_t      op_a;
        operand_t      op_b;
        operand_result result;
    } instruction_t;
endpackage

module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  address_t      start_addr,
    input  logic [5:0]    count,
    output address_t      read_pointer,
    input  instruction_t  instruction_word,
    output operand_result result,
    output opcode_t       result_opc,
    output address_t      result_addr,
    output logic          result_err,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, OUT} state_t;

    state_t      state;
    logic [5:0]  remaining;
    opcode_t     cur_opc;
    operand_t    cur_a;
    operand_t    cur_b;
    address_t    cur_addr;
    logic [4:0]  iter;

    // Restoring divider state: div_q shifts the dividend magnitude out and the
    // quotient bits in; div_r is the partial remainder; div_d the divisor.
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_d;

    // Right-to-left square-and-multiply state, all modulo 2^64.
    logic [63:0] pow_acc;
    logic [63:0] pow_base;
    logic [31:0] pow_exp;

    logic [31:0] fetch_a_mag;
    logic [31:0] fetch_b_mag;
    logic [32:0] rem_shift;
    logic [32:0] trial;
    logic [31:0] div_q_nxt;
    logic [31:0] div_r_nxt;
    logic [63:0] pow_acc_nxt;
    logic [63:0] pow_base_nxt;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] quo_mag;
    logic [63:0] rem_mag;
    logic [63:0] exec_res;
    logic        exec_err;
    logic        is_iter;
    logic        unused_result_bits;

    assign busy = (state != IDLE);

    // The stored result field of the instruction is never consumed here.
    assign unused_result_bits = ^instruction_word.result;

    // Operand magnitudes for the divider, taken straight from the fetched
    // word so they can be loaded in the FETCH cycle. The magnitude of -2^31
    // is 2^31, which still fits in 32 unsigned bits.
    always_comb begin
        fetch_a_mag = instruction_word.op_a[31] ? (~instruction_word.op_a + 32'd1)
                                                : instruction_word.op_a;
        fetch_b_mag = instruction_word.op_b[31] ? (~instruction_word.op_b + 32'd1)
                                                : instruction_word.op_b;
    end

    // One divider step, one power step, and the final result selection for
    // the opcode currently in EXEC. Iterative ops use the "next" values so
    // that the last (32nd) step lands directly in the result register.
    always_comb begin
        rem_shift = {div_r, div_q[31]};
        trial     = rem_shift - {1'b0, div_d};
        if (trial[32]) begin
            div_r_nxt = rem_shift[31:0];
            div_q_nxt = {div_q[30:0], 1'b0};
        end else begin
            div_r_nxt = trial[31:0];
            div_q_nxt = {div_q[30:0], 1'b1};
        end

        pow_acc_nxt  = pow_exp[0] ? (pow_acc * pow_base) : pow_acc;
        pow_base_nxt = pow_base * pow_base;

        a_ext   = {{32{cur_a[31]}}, cur_a};
        b_ext   = {{32{cur_b[31]}}, cur_b};
        quo_mag = {32'd0, div_q_nxt};
        rem_mag = {32'd0, div_r_nxt};

        exec_res = '0;
        exec_err = 1'b0;
        is_iter  = 1'b0;
        case (cur_opc)
            ZERO:  exec_res = '0;
            PASSA: exec_res = a_ext;
            PASSB: exec_res = b_ext;
            ADD:   exec_res = a_ext + b_ext;
            SUB:   exec_res = a_ext - b_ext;
            MULT:  exec_res = a_ext * b_ext;
            DIV: begin
                is_iter = 1'b1;
                if (cur_b == '0) begin
                    exec_err = 1'b1;
                end else begin
                    exec_res = (cur_a[31] ^ cur_b[31]) ? -quo_mag : quo_mag;
                end
            end
            MOD: begin
                is_iter = 1'b1;
                if (cur_b == '0) begin
                    exec_err = 1'b1;
                end else begin
                    exec_res = cur_a[31] ? -rem_mag : rem_mag;
                end
            end
            POW: begin
                is_iter  = 1'b1;
                exec_res = cur_b[31] ? 64'd0 : pow_acc_nxt;
            end
            default: exec_err = 1'b1;
        endcase
    end

    // Main sequencer: IDLE -> FETCH -> EXEC (1 or 32 cycles) -> OUT, looping
    // back to FETCH until the requested number of results has been accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            remaining    <= '0;
            read_pointer <= '0;
            cur_opc      <= ZERO;
            cur_a        <= '0;
            cur_b        <= '0;
            cur_addr     <= '0;
            iter         <= '0;
            div_q        <= '0;
            div_r        <= '0;
            div_d        <= '0;
            pow_acc      <= '0;
            pow_base     <= '0;
            pow_exp      <= '0;
            result       <= '0;
            result_opc   <= ZERO;
            result_addr  <= '0;
            result_err   <= 1'b0;
            result_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count != 6'd0) begin
                            read_pointer <= start_addr;
                            remaining    <= count;
                            state        <= FETCH;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    cur_opc  <= instruction_word.opc;
                    cur_a    <= instruction_word.op_a;
                    cur_b    <= instruction_word.op_b;
                    cur_addr <= read_pointer;
                    iter     <= '0;
                    div_q    <= fetch_a_mag;
                    div_r    <= '0;
                    div_d    <= fetch_b_mag;
                    pow_acc  <= 64'd1;
                    pow_base <= {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
                    pow_exp  <= instruction_word.op_b;
                    state    <= EXEC;
                end
                EXEC: begin
                    div_q    <= div_q_nxt;
                    div_r    <= div_r_nxt;
                    pow_acc  <= pow_acc_nxt;
                    pow_base <= pow_base_nxt;
                    pow_exp  <= pow_exp >> 1;
                    iter     <= iter + 5'd1;
                    if (!is_iter || (iter == 5'd31)) begin
                        result       <= exec_res;
                        result_err   <= exec_err;
                        result_opc   <= cur_opc;
                        result_addr  <= cur_addr;
                        result_valid <= 1'b1;
                        state        <= OUT;
                    end
                end
                OUT: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        remaining    <= remaining - 6'd1;
                        if (remaining == 6'd1) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            read_pointer <= read_pointer + 5'd1;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_exec_unit.sv
// tb_instr_exec_unit
// ---------------------------------------------------------------------------
// Scoreboard bench for instr_exec_unit. The stimulus process loads a small
// instruction-register model, pushes hand-computed expected results into a
// queue and starts a run; an independent monitor pops and compares at every
// output handshake, checks stability under backpressure and the cycle at
// which each result first becomes valid relative to the start edge.
// ---------------------------------------------------------------------------

module tb_instr_exec_unit;
    import instr_register_pkg::*;

    typedef struct {
        operand_result res;
        opcode_t       opc;
        address_t      addr;
        logic          err;
        int            rel_rise;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          start;
    address_t      start_addr;
    logic [5:0]    count;
    address_t      read_pointer;
    instruction_t  instruction_word;
    operand_result result;
    opcode_t       result_opc;
    address_t      result_addr;
    logic          result_err;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic          done;

    instruction_t  mem [32];
    exp_t          sb [$];
    exp_t          mon_e;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int seq_e0      = 0;
    int done_count  = 0;
    int last_rise   = 0;
    int stall_cnt   = 0;
    bit stall_mode  = 1'b0;

    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    operand_result prev_result;
    logic [9:0]    prev_tag;

    instr_exec_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .start_addr       (start_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .result           (result),
        .result_opc       (result_opc),
        .result_addr      (result_addr),
        .result_err       (result_err),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational instruction register model.
    assign instruction_word = mem[read_pointer];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic setInstr(input address_t addr, input opcode_t opc,
                            input operand_t a, input operand_t b);
        mem[addr].opc    = opc;
        mem[addr].op_a   = a;
        mem[addr].op_b   = b;
        mem[addr].result = 64'hDEAD_BEEF_DEAD_BEEF;
    endtask

    task automatic expectRes(input operand_result res, input opcode_t opc,
                             input address_t addr, input logic err, input int rel);
        exp_t e;
        e.res      = res;
        e.opc      = opc;
        e.addr     = addr;
        e.err      = err;
        e.rel_rise = rel;
        sb.push_back(e);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_read_pointer"}, read_pointer, 0);
        checkOutput({tag, "_result"}, result, 0);
        checkOutput({tag, "_result_opc"}, result_opc, ZERO);
        checkOutput({tag, "_result_addr"}, result_addr, 0);
        checkOutput({tag, "_result_err"}, result_err, 0);
        checkOutput({tag, "_result_valid"}, result_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
    endtask

    // Issue one run and wait (bounded) for its completion. Optionally pulse a
    // second start mid-run, which the unit must ignore.
    task automatic applyStimulus(input address_t addr, input logic [5:0] n,
                                 input int budget, input bit inject);
        int d0;
        bit finished;
        @(posedge clk);
        #1;
        d0         = done_count;
        seq_e0     = cyc + 1;
        start      = 1'b1;
        start_addr = addr;
        count      = n;
        @(posedge clk);
        #1;
        start    = 1'b0;
        finished = 1'b0;
        for (int k = 0; k < budget && !finished; k++) begin
            @(negedge clk);
            #1;
            if (inject && k == 20) begin
                start      = 1'b1;
                start_addr = 5'd10;
                count      = 6'd1;
            end
            if (inject && k == 21) start = 1'b0;
            if (done_count != d0 && !busy) finished = 1'b1;
        end
        checkOutput("sequence_completed", finished, 1);
        checkOutput("done_pulses", 64'(done_count - d0), 1);
        checkOutput("busy_low_at_end", busy, 0);
        checkOutput("scoreboard_drained", 64'(sb.size()), 0);
    endtask

    // Consumer: either always ready, or holds ready low for 5 cycles on each
    // presented result before accepting it.
    initial begin
        result_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                if (result_valid && !result_ready) begin
                    if (stall_cnt == 4) result_ready = 1'b1;
                    else stall_cnt++;
                end else begin
                    result_ready = 1'b0;
                    stall_cnt    = 0;
                end
            end else begin
                result_ready = 1'b1;
            end
        end
    end

    // Monitor: compares at each handshake, checks hold-while-stalled behaviour
    // and records when each result first appears.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (done) done_count++;
            if (prev_valid && !prev_ready)
                checkOutput("valid_held_while_stalled", result_valid, 1);
            if (result_valid) begin
                if (prev_valid && !prev_ready) begin
                    checkOutput("stall_result_stable", result, prev_result);
                    checkOutput("stall_tag_stable",
                                {54'd0, result_opc, result_addr, result_err},
                                {54'd0, prev_tag});
                end else begin
                    last_rise = cyc;
                end
                if (result_ready) begin
                    checkOutput("sb_has_entry", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mon_e = sb.pop_front();
                        checkOutput("result", result, mon_e.res);
                        checkOutput("result_opc", result_opc, mon_e.opc);
                        checkOutput("result_addr", result_addr, mon_e.addr);
                        checkOutput("result_err", result_err, mon_e.err);
                        if (mon_e.rel_rise >= 0)
                            checkOutput("valid_latency", 64'(last_rise - seq_e0),
                                        64'(mon_e.rel_rise));
                    end
                end
            end
            prev_valid  = result_valid;
            prev_ready  = result_ready;
            prev_result = result;
            prev_tag    = {result_opc, result_addr, result_err};
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int d0;
        reset_n    = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        for (int i = 0; i < 32; i++) setInstr(address_t'(i), ZERO, 0, 0);

        #2 reset_n = 1'b0;
        #1 checkResetValues("por");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;

        // Abort a DIV in flight with an asynchronous reset.
        $display("[TB] reset during DIV");
        setInstr(5'd5, DIV, 100, 7);
        @(posedge clk);
        #1;
        start = 1'b1; start_addr = 5'd5; count = 6'd1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        checkOutput("busy_mid_div", busy, 1);
        checkOutput("read_pointer_mid_div", read_pointer, 5);
        d0 = done_count;
        reset_n = 1'b0;
        #1 checkResetValues("abort");
        #3 reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("busy_after_abort", busy, 0);
        checkOutput("no_done_after_abort", 64'(done_count - d0), 0);

        $display("[TB] start with count 0");
        applyStimulus(5'd7, 6'd0, 20, 1'b0);

        $display("[TB] ADD / SUB / MULT");
        setInstr(5'd0, ADD, 5, -7);
        setInstr(5'd1, SUB, -3, 4);
        setInstr(5'd2, MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        expectRes(-2, ADD, 5'd0, 1'b0, 2);
        expectRes(-7, SUB, 5'd1, 1'b0, 5);
        expectRes(64'h3FFF_FFFF_0000_0001, MULT, 5'd2, 1'b0, 8);
        applyStimulus(5'd0, 6'd3, 100, 1'b0);

        $display("[TB] DIV / MOD");
        setInstr(5'd3, DIV, -7, 2);
        setInstr(5'd4, MOD, -7, 2);
        setInstr(5'd5, DIV, 32'h8000_0000, -1);
        setInstr(5'd6, DIV, 9, 0);
        expectRes(-3, DIV, 5'd3, 1'b0, 33);
        expectRes(-1, MOD, 5'd4, 1'b0, 67);
        expectRes(64'h0000_0000_8000_0000, DIV, 5'd5, 1'b0, 101);
        expectRes(0, DIV, 5'd6, 1'b1, 135);
        applyStimulus(5'd3, 6'd4, 300, 1'b0);

        $display("[TB] POW and illegal opcode");
        setInstr(5'd7, POW, 3, 4);
        setInstr(5'd8, POW, -2, 3);
        setInstr(5'd9, POW, 5, 0);
        setInstr(5'd10, POW, 7, -1);
        setInstr(5'd11, POW, 2, 70);
        setInstr(5'd12, opcode_t'(4'd12), 11, 22);
        expectRes(81, POW, 5'd7, 1'b0, 33);
        expectRes(-8, POW, 5'd8, 1'b0, 67);
        expectRes(1, POW, 5'd9, 1'b0, 101);
        expectRes(0, POW, 5'd10, 1'b0, 135);
        expectRes(0, POW, 5'd11, 1'b0, 169);
        expectRes(0, opcode_t'(4'd12), 5'd12, 1'b1, 172);
        applyStimulus(5'd7, 6'd6, 400, 1'b0);

        $display("[TB] backpressure with address wrap");
        setInstr(5'd30, ADD, 100, 23);
        setInstr(5'd31, PASSB, 1, -9);
        expectRes(123, ADD, 5'd30, 1'b0, -1);
        expectRes(-9, PASSB, 5'd31, 1'b0, -1);
        expectRes(-2, ADD, 5'd0, 1'b0, -1);
        expectRes(-7, SUB, 5'd1, 1'b0, -1);
        stall_mode = 1'b1;
        applyStimulus(5'd30, 6'd4, 200, 1'b1);
        stall_mode = 1'b0;

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
